// File: rtl/simon_ks_ctrl_if.sv
// rtl/simon_ks_ctrl_if.sv - key intake and round-key stream bundle for simon_ks_ctrl
interface simon_ks_ctrl_if #(
  parameter int KEY_W  = 128,
  parameter int WORD_W = 64
);
  logic [KEY_W-1:0]  key_in;
  logic              key_valid;
  logic              key_ready;
  logic [WORD_W-1:0] rk_out;
  logic [6:0]        rk_idx;
  logic              rk_valid;
  logic              rk_ready;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_idx, rk_valid
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_idx, rk_valid
  );
endinterface

// File: rtl/simon_ks_ctrl.sv
// rtl/simon_ks_ctrl.sv - sequencer for the serial SIMON-128/128 key-schedule datapath
module simon_ks_ctrl #(
  parameter int ROUNDS = 68,
  parameter int KEY_W  = 128,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  simon_ks_ctrl_if.slave    bus,
  output logic              ks_data_in,
  output logic [1:0]        ks_data_rdy,
  output logic [7:0]        ks_counter,
  input  logic [WORD_W-1:0] ks_key_out,
  output logic              busy,
  output logic              done
);

  localparam int            BW       = $clog2(KEY_W);
  localparam logic [7:0]    LAST_CNT = 8'(2 * ROUNDS - 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(KEY_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [7:0]       counter;
  logic             in_work;
  logic             run_end;

  assign in_work = (state == S_LOAD) || (state == S_RUN);
  // Final key handshake: even counter at its last value with the consumer ready.
  assign run_end = (state == S_RUN) && !counter[0] && bus.rk_ready && (counter == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.key_valid) state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (bitcnt == LAST_BIT) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)        state_nxt = S_IDLE;
        else if (run_end) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift register drains to zero during LOAD, so ks_data_in idles low without gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bitcnt  <= '0;
      counter <= '0;
    end else if (abort && in_work) begin
      shreg   <= '0;
      bitcnt  <= '0;
      counter <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.key_valid) begin
            shreg   <= bus.key_in;
            bitcnt  <= '0;
            counter <= '0;
          end
        end
        S_LOAD: begin
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) counter <= '0;
        end
        S_RUN: begin
          if (counter[0])        counter <= counter + 8'd1;
          else if (run_end)      counter <= '0;
          else if (bus.rk_ready) counter <= counter + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.key_ready = (state == S_IDLE);
    ks_data_rdy   = 2'd0;
    if (state == S_LOAD)     ks_data_rdy = 2'd2;
    else if (state == S_RUN) ks_data_rdy = 2'd3;
    ks_data_in    = shreg[0];
    ks_counter    = counter;
    bus.rk_valid  = (state == S_RUN) && !counter[0];
    bus.rk_idx    = counter[7:1];
    busy          = in_work;
    done          = (state == S_DONE);
  end

  assign bus.rk_out = ks_key_out;

endmodule

// File: tb/tb_simon_ks_ctrl.sv
// tb/tb_simon_ks_ctrl.sv - randomized self-checking bench for simon_ks_ctrl
module tb_simon_ks_ctrl;
  localparam int ROUNDS = 68;
  localparam logic [127:0] SPEC_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic         ks_data_in;
  logic [1:0]   ks_data_rdy;
  logic [7:0]   ks_counter;
  logic [63:0]  ks_key_out;
  logic         busy;
  logic         done;
  logic [127:0] dp;
  logic [63:0]  exp_rk [0:ROUNDS-1];
  int           tests = 0;
  int           fails = 0;

  simon_ks_ctrl_if #(.KEY_W(128), .WORD_W(64)) bus ();

  simon_ks_ctrl #(.ROUNDS(ROUNDS), .KEY_W(128), .WORD_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .bus         (bus),
    .ks_data_in  (ks_data_in),
    .ks_data_rdy (ks_data_rdy),
    .ks_counter  (ks_counter),
    .ks_key_out  (ks_key_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic zbit(input int i);
    logic [61:0] z;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    return z[61 - (i % 62)];
  endfunction

  // SIMON-128/128 (m=2): k[i+2] = c ^ z[i] ^ k[i] ^ (I ^ S^-1) S^-3 k[i+1]
  function automatic logic [63:0] next_word(input logic [63:0] k0, input logic [63:0] k1, input int i);
    logic [63:0] t;
    t = ror64(k1, 3);
    t = t ^ ror64(t, 1);
    return ~k0 ^ t ^ {63'd0, zbit(i)} ^ 64'd3;
  endfunction

  // Datapath stand-in: KX = dp[127:64], KY = dp[63:0]
  always @(posedge clk) begin
    if (ks_data_rdy == 2'd2)
      dp <= {ks_data_in, dp[127:1]};
    else if (ks_data_rdy == 2'd3 && ks_counter[0])
      dp <= {next_word(dp[63:0], dp[127:64], int'(ks_counter[7:1])), dp[127:64]};
  end
  assign ks_key_out = dp[63:0];

  task automatic compute_ref(input logic [127:0] key);
    exp_rk[0] = key[63:0];
    exp_rk[1] = key[127:64];
    for (int i = 0; i < ROUNDS - 2; i++) exp_rk[i+2] = next_word(exp_rk[i], exp_rk[i+1], i);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, ks_data_rdy, 2'd0);
    chk({tag, "_key_ready"}, bus.key_ready, 1'b1);
    chk({tag, "_rk_valid"}, bus.rk_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // mode 0: rk_ready=1, 1: 5-cycle stall at idx 10, 2: random rk_ready
  task automatic run_key(input logic [127:0] key, input int mode, input bit hold,
                         input int ab_bit, input int ab_idx, input bit use_rst);
    logic [127:0] got;
    logic [63:0]  prev_rk;
    logic [6:0]   prev_idx;
    int nload, cyc, idx, guard, stall, perr;
    bit pending, seen, r;
    compute_ref(key);
    bus.key_in = key;
    bus.key_valid = 1'b1;
    chk("hs_key_ready", bus.key_ready, 1'b1);
    cyc = 0;
    @(negedge clk); cyc++;
    if (!hold) bus.key_valid = 1'b0;
    nload = 0; got = '0; perr = 0;
    while (ks_data_rdy == 2'd2 && nload < 200) begin
      if (nload < 128) got[nload] = ks_data_in;
      if (bus.key_ready !== 1'b0 || busy !== 1'b1) perr++;
      if (nload == ab_bit) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_load");
        return;
      end
      nload++;
      @(negedge clk); cyc++;
    end
    chk("load_cycles", nload, 128);
    chk("load_bits", got, key);
    idx = 0; pending = 0; guard = 0; seen = 0; stall = 0;
    while (!seen && guard < 3000) begin
      if (done) seen = 1;
      else begin
        if (ks_data_rdy !== 2'd3 || bus.key_ready !== 1'b0 || busy !== 1'b1) perr++;
        if (bus.rk_valid) begin
          if (pending) begin
            chk("stable_rk_out", bus.rk_out, prev_rk);
            chk("stable_rk_idx", bus.rk_idx, prev_idx);
          end else begin
            if (idx == ab_idx) begin
              bus.rk_ready = 1'b0;
              if (use_rst) begin
                #2 rst_n = 1'b0;
                #1 chk_idle("async_rst");
                @(negedge clk);
                chk_idle("rst_next");
                rst_n = 1'b1;
              end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_idle("abort_run");
              end
              return;
            end
            chk("rk_idx", bus.rk_idx, idx);
            if (idx < ROUNDS) chk("rk_out", bus.rk_out, exp_rk[idx]);
            else chk("rk_overrun", idx, ROUNDS - 1);
          end
          prev_rk = bus.rk_out;
          prev_idx = bus.rk_idx;
          r = 1'b1;
          if (mode == 1 && idx == 10 && stall < 5) begin
            chk("stall_counter", ks_counter, 8'd20);
            r = 1'b0;
            stall++;
          end else if (mode == 2) r = 1'($urandom_range(0, 1));
          bus.rk_ready = r;
          if (r) begin idx++; pending = 0; end
          else pending = 1;
        end else bus.rk_ready = 1'($urandom_range(0, 1));
      end
      if (!seen) begin
        @(negedge clk); cyc++; guard++;
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("keys_accepted", idx, ROUNDS);
    chk("busy_protocol", perr, 0);
    if (mode == 0) chk("done_latency", cyc, 128 + 2 * ROUNDS);
    if (mode == 1) chk("stall_cycles", stall, 5);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk_idle("after_done");
  endtask

  initial begin
    bus.key_in = '0;
    bus.key_valid = 1'b0;
    bus.rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_data_in", ks_data_in, 1'b0);
    chk("reset_counter", ks_counter, 8'd0);
    chk("reset_rk_idx", bus.rk_idx, 7'd0);
    chk("reset_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    run_key(SPEC_KEY, 0, 0, -1, -1, 0);
    run_key(SPEC_KEY, 1, 0, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 2, 0, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 0, 0, 60, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 0, 0, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 0, 0, -1, 30, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 2, 0, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 2, 0, -1, 30, 1);
    run_key(SPEC_KEY, 0, 0, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 0, 1, -1, -1, 0);
    run_key({$urandom, $urandom, $urandom, $urandom}, 2, 0, -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
